// File: rtl/adc_frame_ram_writer.sv
// adc_frame_ram_writer
//   Receive side of the ADC sample-dump UART link. Hunts for HDR_LEN
//   consecutive HDR_BYTE values. It then writes PAY_LEN payload bytes to a
//   sample RAM at addresses 0..PAY_LEN-1. Finally it checks for a 0x0D 0x0A
//   trailer. A good frame gives a frameDone pulse. A bad trailer or an
//   inter-byte timeout gives a frameErr pulse.
//
// Parameters
//   HDR_BYTE  header byte value
//   HDR_LEN   consecutive header bytes required (1..15)
//   PAY_LEN   payload bytes per frame (1..2**ADDR_W)
//   ADDR_W    RAM address width
//   TIMEOUT   max clk cycles between bytes inside a frame
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   rxEnable   0 holds the parser in IDLE and ignores bytes
//   rxData     byte from the UART receiver
//   rxValid    one-cycle strobe qualifying rxData
//   ramWrAddr  RAM write address (holds between writes)
//   ramWrData  RAM write data (holds between writes)
//   ramWe      RAM write enable, one-cycle pulse
//   frameDone  one-cycle pulse, good frame received
//   frameErr   one-cycle pulse, trailer mismatch or timeout
//   writeBusy  high while in PAY, TR0 or TR1
module adc_frame_ram_writer #(
  parameter logic [7:0] HDR_BYTE = 8'hA0,
  parameter int unsigned HDR_LEN  = 3,
  parameter int unsigned PAY_LEN  = 200,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 100000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rxEnable,
  input  logic [7:0]        rxData,
  input  logic              rxValid,
  output logic [ADDR_W-1:0] ramWrAddr,
  output logic [7:0]        ramWrData,
  output logic              ramWe,
  output logic              frameDone,
  output logic              frameErr,
  output logic              writeBusy
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0]        HDR_LAST = 4'(HDR_LEN - 1);
  localparam logic [ADDR_W-1:0] PAY_LAST = ADDR_W'(PAY_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_TR0,
    S_TR1
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        hdrCnt_q, hdrCnt_d;
  logic [ADDR_W-1:0] payCnt_q, payCnt_d;
  logic [GAP_W-1:0]  gapCnt_q, gapCnt_d;
  logic [ADDR_W-1:0] ramWrAddr_q, ramWrAddr_d;
  logic [7:0]        ramWrData_q, ramWrData_d;
  logic              ramWe_q, ramWe_d;
  logic              frameDone_q, frameDone_d;
  logic              frameErr_q, frameErr_d;
  logic              writeBusy_q, writeBusy_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      hdrCnt_q    <= '0;
      payCnt_q    <= '0;
      gapCnt_q    <= '0;
      ramWrAddr_q <= '0;
      ramWrData_q <= '0;
      ramWe_q     <= 1'b0;
      frameDone_q <= 1'b0;
      frameErr_q  <= 1'b0;
      writeBusy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdrCnt_q    <= hdrCnt_d;
      payCnt_q    <= payCnt_d;
      gapCnt_q    <= gapCnt_d;
      ramWrAddr_q <= ramWrAddr_d;
      ramWrData_q <= ramWrData_d;
      ramWe_q     <= ramWe_d;
      frameDone_q <= frameDone_d;
      frameErr_q  <= frameErr_d;
      writeBusy_q <= writeBusy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hdrCnt_d    = hdrCnt_q;
    payCnt_d    = payCnt_q;
    gapCnt_d    = gapCnt_q;
    ramWrAddr_d = ramWrAddr_q;
    ramWrData_d = ramWrData_q;
    ramWe_d     = 1'b0;
    frameDone_d = 1'b0;
    frameErr_d  = 1'b0;

    if (!rxEnable) begin
      // Disable is a silent abort: no error pulse, and the RAM is left as it is.
      state_d  = S_IDLE;
      hdrCnt_d = '0;
      payCnt_d = '0;
      gapCnt_d = '0;
    end else if (rxValid) begin
      // A byte in the final gap cycle wins over the timeout.
      gapCnt_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (rxData == HDR_BYTE) begin
            hdrCnt_d = 4'd1;
            payCnt_d = '0;
            state_d  = (HDR_LEN == 1) ? S_PAY : S_HDR;
          end
        end
        S_HDR: begin
          if (rxData == HDR_BYTE) begin
            if (hdrCnt_q == HDR_LAST) begin
              hdrCnt_d = '0;
              payCnt_d = '0;
              state_d  = S_PAY;
            end else begin
              hdrCnt_d = hdrCnt_q + 4'd1;
            end
          end else begin
            hdrCnt_d = '0;
            state_d  = S_IDLE;
          end
        end
        S_PAY: begin
          ramWe_d     = 1'b1;
          ramWrAddr_d = payCnt_q;
          ramWrData_d = rxData;
          if (payCnt_q == PAY_LAST) begin
            payCnt_d = '0;
            state_d  = S_TR0;
          end else begin
            payCnt_d = payCnt_q + 1'b1;
          end
        end
        S_TR0: begin
          if (rxData == 8'h0D) begin
            state_d = S_TR1;
          end else begin
            frameErr_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
        S_TR1: begin
          if (rxData == 8'h0A) frameDone_d = 1'b1;
          else                 frameErr_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (gapCnt_q == GAP_LAST) begin
        frameErr_d = 1'b1;
        state_d    = S_IDLE;
        hdrCnt_d   = '0;
        payCnt_d   = '0;
        gapCnt_d   = '0;
      end else begin
        gapCnt_d = gapCnt_q + 1'b1;
      end
    end

    writeBusy_d = (state_d == S_PAY) || (state_d == S_TR0) || (state_d == S_TR1);
  end

  assign ramWrAddr = ramWrAddr_q;
  assign ramWrData = ramWrData_q;
  assign ramWe     = ramWe_q;
  assign frameDone = frameDone_q;
  assign frameErr  = frameErr_q;
  assign writeBusy = writeBusy_q;

endmodule
